gamma_controller: RTL

Gamma-cycle sequencer for the temporal (race-logic) datapath. It generates the 1-cycle `grst` pulse that frames every gamma cycle and broadcasts the current unit-time tick. It time-stamps the first arrival on each of N operator/neuron output lines and hands one timestamp vector per gamma cycle downstream over a valid/ready handshake. It sits above arrays of temporal operators such as less-equal, inhibit and min/max, and drives their `grst` input.

---
 rtl/gamma_pkg.sv | 15 +
 rtl/spike_capture.sv | 37 +++
 rtl/gamma_controller.sv | 134 +++++++++++++
 3 files changed

// File: rtl/gamma_pkg.sv
// Shared types and helpers for the gamma-cycle sequencer and its capture lanes.
package gamma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GRST = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Timestamp width for a given gamma length; one code is reserved as the null marker.
  function automatic int ts_width(input int gamma_len);
    return (gamma_len <= 2) ? 1 : $clog2(gamma_len);
  endfunction

endpackage

// File: rtl/spike_capture.sv
// One monitored spike line: latches the tick of the first arrival while armed.
module spike_capture
  import gamma_pkg::*;
#(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          arm,
  input  logic          spike,
  input  logic [TW-1:0] tick,
  output logic          seen,
  output logic [TW-1:0] ts
);

  logic          r_seen;
  logic [TW-1:0] r_ts;

  // First arrival wins; later activity on the line is ignored until the next clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seen <= 1'b0;
      r_ts   <= '0;
    end else if (clr) begin
      r_seen <= 1'b0;
      r_ts   <= '0;
    end else if (arm && spike && !r_seen) begin
      r_seen <= 1'b1;
      r_ts   <= tick;
    end
  end

  assign seen = r_seen;
  assign ts   = r_ts;

endmodule

// File: rtl/gamma_controller.sv
// Gamma-cycle sequencer: frames gamma cycles with grst, broadcasts tick, and
// delivers one first-arrival timestamp vector per gamma over valid/ready.
module gamma_controller
  import gamma_pkg::*;
#(
  parameter int GAMMA_LEN = 16,
  parameter int N_IN      = 8,
  parameter int TW        = ts_width(GAMMA_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  output logic               grst,
  output logic [TW-1:0]      tick,
  output logic               busy,
  input  logic [N_IN-1:0]    spike_in,
  output logic [N_IN*TW-1:0] ts_data,
  output logic [N_IN-1:0]    ts_null,
  output logic               ts_valid,
  input  logic               ts_ready,
  output logic               overrun
);

  localparam logic [TW-1:0] LAST_TICK = TW'(GAMMA_LEN - 2);
  localparam logic [TW-1:0] NULL_TS   = '1;

  state_t              r_state;
  state_t              w_next_state;
  logic [TW-1:0]       r_tick;
  logic [TW-1:0]       w_next_tick;

  logic                w_clr;
  logic                w_arm;
  logic                w_load;
  logic [N_IN-1:0]     w_seen;
  logic [N_IN*TW-1:0]  w_cap_ts;
  logic [N_IN*TW-1:0]  w_res_data;
  logic [N_IN-1:0]     w_res_null;

  logic                r_valid;
  logic                r_overrun;
  logic [N_IN*TW-1:0]  r_data;
  logic [N_IN-1:0]     r_null;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_tick  <= '0;
    end else begin
      r_state <= w_next_state;
      r_tick  <= w_next_tick;
    end
  end

  // Tick only advances while staying in RUN, so it reads 0 in IDLE and GRST.
  always_comb begin
    w_next_state = r_state;
    w_next_tick  = '0;
    case (r_state)
      IDLE: if (enable) w_next_state = GRST;
      GRST: w_next_state = RUN;
      RUN: begin
        if (r_tick == LAST_TICK) begin
          w_next_state = enable ? GRST : IDLE;
        end else begin
          w_next_tick = r_tick + TW'(1);
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_clr  = (r_state == GRST);
  assign w_arm  = (r_state == RUN);
  assign w_load = w_arm && (r_tick == LAST_TICK);

  for (genvar g = 0; g < N_IN; g++) begin : g_line
    spike_capture #(.TW(TW)) u_capture (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_clr),
      .arm   (w_arm),
      .spike (spike_in[g]),
      .tick  (r_tick),
      .seen  (w_seen[g]),
      .ts    (w_cap_ts[g*TW +: TW])
    );
  end

  // Result as it stands after the final RUN cycle, folding in spikes sampled on that edge.
  always_comb begin
    w_res_data = '0;
    w_res_null = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (w_seen[i]) begin
        w_res_data[i*TW +: TW] = w_cap_ts[i*TW +: TW];
      end else if (spike_in[i]) begin
        w_res_data[i*TW +: TW] = r_tick;
      end else begin
        w_res_data[i*TW +: TW] = NULL_TS;
        w_res_null[i]          = 1'b1;
      end
    end
  end

  // A load beats a same-edge transfer; a load into a stalled slot is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_data    <= '0;
      r_null    <= '0;
    end else if (w_load) begin
      if (r_valid && !ts_ready) begin
        r_overrun <= 1'b1;
      end else begin
        r_valid <= 1'b1;
        r_data  <= w_res_data;
        r_null  <= w_res_null;
      end
    end else if (r_valid && ts_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign grst     = (r_state == GRST);
  assign busy     = (r_state != IDLE);
  assign tick     = r_tick;
  assign ts_data  = r_data;
  assign ts_null  = r_null;
  assign ts_valid = r_valid;
  assign overrun  = r_overrun;

endmodule
